// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared definitions for the 3x3 window generator and the convolution stage
//   that consumes its windows.
//   - Default pixel format (integer + fractional bits) and the derived pixel width.
//   - pixel_t: one fixed-point pixel at the default width.
//   - Window geometry constants and a helper that gives the packed window width.
//   - state_e: window generator phase (filling line buffers / streaming windows).
package conv_pkg;

  localparam int DEFAULT_INTEGER_BITS     = 8;
  localparam int DEFAULT_FIXED_POINT_BITS = 4;
  localparam int PIXEL_W                  = DEFAULT_INTEGER_BITS + DEFAULT_FIXED_POINT_BITS;
  localparam int WINDOW_DIM               = 3;
  localparam int WINDOW_PIXELS            = WINDOW_DIM * WINDOW_DIM;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [0:0] {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  // Packed width of one 3x3 window for a given pixel width.
  function automatic int window_width(input int pw);
    return WINDOW_PIXELS * pw;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
//   One image line of storage. A single address serves both the read and the
//   write port; the read is combinational, so on an accepting edge the value
//   read is the one stored before that edge (read-before-write).
//   Contents are not reset: the window generator never emits a window that
//   depends on rows not yet written in the current frame.
// Ports
//   i_clk    clock
//   i_we     write enable (one accepted pixel)
//   i_addr   column address for both ports
//   i_wdata  data written at i_addr
//   o_rdata  data currently stored at i_addr
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = PIXEL_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign o_rdata = mem_q[i_addr];

  // Line storage write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Turns a raster-order pixel stream into packed 3x3 neighbourhood windows
//   for the convolution stage. Two line buffers hold the previous two rows;
//   a two-column history plus the incoming column forms each window.
// Ports
//   i_clk               clock, rising edge
//   i_rstn              synchronous reset, active low
//   i_pixel             incoming pixel (raster order)
//   i_pixel_valid       i_pixel is valid this cycle
//   i_sof               start of frame, qualified by i_pixel_valid
//   o_pixel_data        packed window, slot k = 3*row_off + col_off at [k*PW +: PW]
//   o_pixel_data_valid  one cycle per emitted window
//   o_frame_done        pulse one cycle after the last pixel of a frame
module window_gen_3x3
  import conv_pkg::*;
#(
  parameter int INTEGER_BITS     = DEFAULT_INTEGER_BITS,
  parameter int FIXED_POINT_BITS = DEFAULT_FIXED_POINT_BITS,
  parameter int IMG_WIDTH        = 32,
  parameter int IMG_HEIGHT       = 32,
  parameter int PW               = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [PW-1:0]       i_pixel,
  input  logic                i_pixel_valid,
  input  logic                i_sof,
  output logic [9*PW-1:0]     o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_frame_done
);

  localparam int WIN_W = 9 * PW;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_ZERO  = CW'(0);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_ZERO  = RW'(0);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_STREAM = RW'(2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

  // A column of the window: [0*PW] = row r-2 (top), [1*PW] = row r-1, [2*PW] = row r.
  typedef logic [3*PW-1:0] column_t;

  logic [CW-1:0]    col_q, col_d, eff_col_s;
  logic [RW-1:0]    row_q, row_d, eff_row_s;
  state_e           state_q, state_d, cur_state_s;
  column_t [1:0]    hist_q, hist_d;
  column_t [2:0]    cols_s;
  logic [WIN_W-1:0] win_s;
  logic [WIN_W-1:0] data_q, data_d;
  logic             valid_q, done_q;
  logic             sof_s, emit_s, last_s;
  logic [PW-1:0]    line_a_rd_s, line_b_rd_s;

  assign sof_s = i_pixel_valid & i_sof;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign eff_col_s   = sof_s ? COL_ZERO : col_q;
  assign eff_row_s   = sof_s ? ROW_ZERO : row_q;
  assign cur_state_s = sof_s ? S_FILL : state_q;

  // lineA holds row r-1; lineB receives what lineA held, so it holds row r-2.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PW), .AW(CW)) u_line_a (
    .i_clk  (i_clk),
    .i_we   (i_pixel_valid),
    .i_addr (eff_col_s),
    .i_wdata(i_pixel),
    .o_rdata(line_a_rd_s)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PW), .AW(CW)) u_line_b (
    .i_clk  (i_clk),
    .i_we   (i_pixel_valid),
    .i_addr (eff_col_s),
    .i_wdata(line_a_rd_s),
    .o_rdata(line_b_rd_s)
  );

  // Raster position counters.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_pixel_valid) begin
      if (eff_col_s == COL_LAST) begin
        col_d = COL_ZERO;
        if (eff_row_s == ROW_LAST) begin
          row_d = ROW_ZERO;
        end else begin
          row_d = eff_row_s + ROW_ONE;
        end
      end else begin
        col_d = eff_col_s + COL_ONE;
        row_d = eff_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Phase tracking: no windows until the third row of a frame arrives.
  always_comb begin
    state_d = cur_state_s;
    case (cur_state_s)
      S_FILL: begin
        if (i_pixel_valid && (row_d == ROW_STREAM)) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_FILL;
        end
      end
      S_STREAM: begin
        if (i_pixel_valid && (row_d == ROW_ZERO)) begin
          state_d = S_FILL;
        end else begin
          state_d = S_STREAM;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Window assembly: two history columns plus the column arriving now.
  always_comb begin
    cols_s[0] = hist_q[0];
    cols_s[1] = hist_q[1];
    cols_s[2] = {i_pixel, line_a_rd_s, line_b_rd_s};
    win_s     = {WIN_W{1'b0}};
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        win_s[(3*dr+dc)*PW +: PW] = cols_s[dc][dr*PW +: PW];
      end
    end
  end

  // Emission control and next values for history and the output window.
  always_comb begin
    // Columns 0 and 1 would wrap across a line boundary, so they never emit.
    emit_s = i_pixel_valid && (cur_state_s == S_STREAM) && (eff_col_s >= COL_FIRST_WIN);
    last_s = i_pixel_valid && (eff_row_s == ROW_LAST) && (eff_col_s == COL_LAST);
    if (i_pixel_valid) begin
      hist_d[0] = hist_q[1];
      hist_d[1] = cols_s[2];
    end else begin
      hist_d = hist_q;
    end
    if (emit_s) begin
      data_d = win_s;
    end else begin
      data_d = data_q;
    end
  end

  // State, counters, history and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col_q   <= COL_ZERO;
      row_q   <= ROW_ZERO;
      state_q <= S_FILL;
      hist_q  <= {2{{(3*PW){1'b0}}}};
      data_q  <= {WIN_W{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      hist_q  <= hist_d;
      data_q  <= data_d;
      valid_q <= emit_s;
      done_q  <= last_s;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 12;
  localparam int WW = 9 * PW;

  logic          clk;
  logic          i_rstn;
  logic [PW-1:0] i_pixel;
  logic          i_pixel_valid;
  logic          i_sof;
  logic [WW-1:0] o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_frame_done;

  window_gen_3x3 #(
    .INTEGER_BITS(8), .FIXED_POINT_BITS(4), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .i_clk             (clk),
    .i_rstn            (i_rstn),
    .i_pixel           (i_pixel),
    .i_pixel_valid     (i_pixel_valid),
    .i_sof             (i_sof),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .o_frame_done      (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the current frame as a flat raster array and a position.
  logic [PW-1:0] img [W*H];
  int            pos = 0;
  logic          exp_valid = 1'b0;
  logic          exp_done  = 1'b0;
  logic [WW-1:0] exp_data  = '0;

  int            n_vec = 0;
  int            n_err = 0;

  // Captures of windows seen since the last clear.
  int            win_cnt = 0;
  logic [WW-1:0] first_win = '0;
  logic [WW-1:0] last_win  = '0;
  logic          last_done = 1'b0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Window whose top-left raster position is tl, for pixel value = base + position.
  function automatic logic [WW-1:0] raster_win(input int base, input int tl);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(base + tl + (k / 3) * W + (k % 3));
    return w;
  endfunction

  task automatic step(input logic rstn, input logic v, input logic sof, input logic [PW-1:0] pix);
    int pe, r, c;
    @(negedge clk);
    i_rstn = rstn; i_pixel_valid = v; i_sof = sof; i_pixel = pix;
    @(posedge clk);
    if (!rstn) begin
      pos = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_data = '0;
    end else if (v) begin
      pe = sof ? 0 : pos;
      r  = pe / W;
      c  = pe % W;
      img[pe] = pix;
      exp_valid = (r >= 2) && (c >= 2);
      if (exp_valid) begin
        for (int k = 0; k < 9; k++) exp_data[k*PW +: PW] = img[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
      end
      exp_done = (pe == W * H - 1);
      pos = (pe + 1) % (W * H);
    end else begin
      exp_valid = 1'b0; exp_done = 1'b0;
    end
    #1;
    chk("valid", WW'(o_pixel_data_valid), WW'(exp_valid));
    chk("frame_done", WW'(o_frame_done), WW'(exp_done));
    chk("data", o_pixel_data, exp_data);
    if (o_pixel_data_valid === 1'b1) begin
      win_cnt++;
      if (win_cnt == 1) first_win = o_pixel_data;
      last_win  = o_pixel_data;
      last_done = o_frame_done;
    end
  endtask

  task automatic clear_caps();
    win_cnt = 0; first_win = '0; last_win = '0; last_done = 1'b0;
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b1, i == 0, PW'(base + i));
      if (gaps) step(1'b1, 1'b0, 1'b0, PW'($urandom));
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_pixel_valid = 1'b0; i_sof = 1'b0; i_pixel = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 12'h5A5);
    step(1'b1, 1'b0, 1'b1, '0);   // sof without valid is ignored

    // Full frame, continuous valid
    clear_caps();
    frame(0, 1'b0);
    chk("t1_count", WW'(win_cnt), WW'(4));
    chk("t1_first", first_win, raster_win(0, 0));
    chk("t1_last", last_win, raster_win(0, 5));
    chk("t1_last_done", WW'(last_done), WW'(1));

    // Same frame with valid gaps
    clear_caps();
    frame(0, 1'b1);
    chk("t2_count", WW'(win_cnt), WW'(4));
    chk("t2_first", first_win, raster_win(0, 0));
    chk("t2_last", last_win, raster_win(0, 5));

    // Two back-to-back frames
    clear_caps();
    frame(0, 1'b0);
    chk("t3_count_a", WW'(win_cnt), WW'(4));
    clear_caps();
    frame(16, 1'b0);
    chk("t3_count_b", WW'(win_cnt), WW'(4));
    chk("t3_first_b", first_win, raster_win(16, 0));

    // Reset mid-frame after pixel 11, then restart
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, i == 0, PW'(i));
    step(1'b0, 1'b0, 1'b0, '0);
    clear_caps();
    for (int i = 0; i < W * H; i++) step(1'b1, 1'b1, 1'b0, PW'(i));
    chk("t4_count", WW'(win_cnt), WW'(4));
    chk("t4_first", first_win, raster_win(0, 0));

    // Start of frame on pixel 6 of a running frame
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i == 0, PW'(i));
    clear_caps();
    frame(100, 1'b0);
    chk("t5_count", WW'(win_cnt), WW'(4));
    chk("t5_first", first_win, raster_win(100, 0));
    chk("t5_last_done", WW'(last_done), WW'(1));

    // Full-width pixel at (2,2)
    clear_caps();
    for (int i = 0; i < W * H; i++) step(1'b1, 1'b1, i == 0, (i == 10) ? 12'hFFF : PW'(i));
    chk("t6_slot8", WW'(first_win[8*PW +: PW]), WW'(12'hFFF));

    // Randomized traffic: gaps, stray sof, occasional reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           PW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
